// File: rtl/dsp48a1_pkg.sv
// Shared constants for the DSP48A1 slice model: opmode bit positions
// and the default operand/product widths.
package dsp48a1_pkg;

  localparam int OPM_PREADD = 4;
  localparam int OPM_SUB    = 6;

  localparam int DEF_A_W = 18;
  localparam int DEF_B_W = 18;
  localparam int DEF_M_W = DEF_A_W + DEF_B_W;

endpackage

// File: rtl/pipe_stage.sv
// One optional pipeline register group with clock enable and async reset.
// When EN is 0 the group collapses to a wire and clk/rst/ce are ignored.
module pipe_stage
  import dsp48a1_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter bit EN    = 1'b1
) (
  input  logic             clk,
  input  logic             rst_aSYNC,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (EN) begin : g_reg
      logic [WIDTH-1:0] q_r;

      // Capture the whole group (data and valid together) only when enabled.
      always_ff @(posedge clk or posedge rst_aSYNC) begin
        if (rst_aSYNC) begin
          q_r <= '0;
        end else if (ce) begin
          q_r <= d;
        end
      end

      assign q = q_r;
    end else begin : g_bypass
      logic unused_ctrl;

      // Control inputs have no meaning for a bypassed stage.
      assign unused_ctrl = ^{clk, rst_aSYNC, ce};
      assign q = d;
    end
  endgenerate

endmodule

// File: rtl/preadd_mult_stage.sv
// Front arithmetic stage of the DSP48A1 slice: stage-0 capture of D/B/A,
// optional D+/-B pre-adder on the B path, stage-1 capture, signed multiply
// and the M register. A valid bit rides alongside every register group so
// that each sample keeps its own opmode and qualifier through the pipe.
module preadd_mult_stage
  import dsp48a1_pkg::*;
#(
  parameter int A_W  = DEF_A_W,
  parameter int B_W  = DEF_B_W,
  parameter bit REG0 = 1'b1,
  parameter bit REG1 = 1'b1,
  parameter bit MREG = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_aSYNC,
  input  logic                 ce0,
  input  logic                 ce1,
  input  logic                 cem,
  input  logic                 in_valid,
  input  logic [7:0]           opmode,
  input  logic [B_W-1:0]       d_in,
  input  logic [B_W-1:0]       b_in,
  input  logic [A_W-1:0]       a_in,
  output logic [B_W-1:0]       bcout,
  output logic [A_W+B_W-1:0]   m_out,
  output logic                 out_valid
);

  localparam int M_W  = A_W + B_W;
  localparam int S0_W = 3 + 2 * B_W + A_W;
  localparam int S1_W = 1 + B_W + A_W;
  localparam int SM_W = 1 + M_W;

  localparam logic [7:0] OPM_USED = (8'b1 << OPM_SUB) | (8'b1 << OPM_PREADD);

  // Opmode bits outside the pre-adder controls belong to later stages.
  logic unused_opmode;
  assign unused_opmode = ^(opmode & ~OPM_USED);

  // Stage 0: opmode copy, valid, D, B, A travel as one group.
  logic [S0_W-1:0] s0_d, s0_q;
  logic [B_W-1:0]  d0, b0;
  logic [A_W-1:0]  a0;
  logic            op4_0, op6_0, v0;

  assign s0_d = {opmode[OPM_SUB], opmode[OPM_PREADD], in_valid, d_in, b_in, a_in};

  pipe_stage #(.WIDTH(S0_W), .EN(REG0)) u_stage0 (
    .clk       (clk),
    .rst_aSYNC (rst_aSYNC),
    .ce        (ce0),
    .d         (s0_d),
    .q         (s0_q)
  );

  assign {op6_0, op4_0, v0, d0, b0, a0} = s0_q;

  // Pre-adder wraps modulo 2^B_W; its result replaces B only when selected.
  logic [B_W-1:0] pre, b1_d;
  assign pre  = op6_0 ? (d0 - b0) : (d0 + b0);
  assign b1_d = op4_0 ? pre : b0;

  // Stage 1: B after the pre-adder, A, and valid.
  logic [S1_W-1:0] s1_d, s1_q;
  logic [B_W-1:0]  b1;
  logic [A_W-1:0]  a1;
  logic            v1;

  assign s1_d = {v0, b1_d, a0};

  pipe_stage #(.WIDTH(S1_W), .EN(REG1)) u_stage1 (
    .clk       (clk),
    .rst_aSYNC (rst_aSYNC),
    .ce        (ce1),
    .d         (s1_d),
    .q         (s1_q)
  );

  assign {v1, b1, a1} = s1_q;
  assign bcout = b1;

  // Full-width signed product; sign-extending both operands first keeps it exact.
  logic signed [M_W-1:0] a_ext, b_ext, prod;
  assign a_ext = M_W'(signed'(a1));
  assign b_ext = M_W'(signed'(b1));
  assign prod  = a_ext * b_ext;

  // M stage: product and valid.
  logic [SM_W-1:0] sm_d, sm_q;
  assign sm_d = {v1, prod};

  pipe_stage #(.WIDTH(SM_W), .EN(MREG)) u_stage_m (
    .clk       (clk),
    .rst_aSYNC (rst_aSYNC),
    .ce        (cem),
    .d         (sm_d),
    .q         (sm_q)
  );

  assign {out_valid, m_out} = sm_q;

endmodule

// File: tb/tb_preadd_mult_stage.sv
// Directed self-checking bench for preadd_mult_stage. Three instances share
// the stimulus: default (1,1,1), fully bypassed (0,0,0) and mixed (1,0,1).
module tb_preadd_mult_stage;

  logic        clk;
  logic        rst_aSYNC;
  logic        ce0, ce1, cem;
  logic        in_valid;
  logic [7:0]  opmode;
  logic [17:0] d_in, b_in, a_in;

  logic [17:0] def_bcout, byp_bcout, mix_bcout;
  logic [35:0] def_m_out, byp_m_out, mix_m_out;
  logic        def_out_valid, byp_out_valid, mix_out_valid;

  int num_checks  = 0;
  int miscompares = 0;

  logic [35:0] stall_m [9] = '{36'd0, 36'd0, 36'd10, 36'd10, 36'd10,
                               36'd20, 36'd30, 36'd40, 36'd0};
  logic        stall_v [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                               1'b1, 1'b1, 1'b1, 1'b0};

  preadd_mult_stage dut_def (
    .clk(clk), .rst_aSYNC(rst_aSYNC), .ce0(ce0), .ce1(ce1), .cem(cem),
    .in_valid(in_valid), .opmode(opmode), .d_in(d_in), .b_in(b_in), .a_in(a_in),
    .bcout(def_bcout), .m_out(def_m_out), .out_valid(def_out_valid)
  );

  preadd_mult_stage #(.REG0(1'b0), .REG1(1'b0), .MREG(1'b0)) dut_byp (
    .clk(clk), .rst_aSYNC(rst_aSYNC), .ce0(ce0), .ce1(ce1), .cem(cem),
    .in_valid(in_valid), .opmode(opmode), .d_in(d_in), .b_in(b_in), .a_in(a_in),
    .bcout(byp_bcout), .m_out(byp_m_out), .out_valid(byp_out_valid)
  );

  preadd_mult_stage #(.REG0(1'b1), .REG1(1'b0), .MREG(1'b1)) dut_mix (
    .clk(clk), .rst_aSYNC(rst_aSYNC), .ce0(ce0), .ce1(ce1), .cem(cem),
    .in_valid(in_valid), .opmode(opmode), .d_in(d_in), .b_in(b_in), .a_in(a_in),
    .bcout(mix_bcout), .m_out(mix_m_out), .out_valid(mix_out_valid)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic apply_stimulus(input logic [17:0] a, input logic [17:0] b,
                                input logic [17:0] d, input logic [7:0] op,
                                input logic v);
    a_in     = a;
    b_in     = b;
    d_in     = d;
    opmode   = op;
    in_valid = v;
  endtask

  task automatic check_output(input string tag, input logic [35:0] observed,
                              input logic [35:0] expected);
    num_checks++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One sample through all three configurations; opmode is cleared after
  // stage-0 capture so a later opmode change must not touch the sample.
  task automatic run_vector(input string tag, input logic [17:0] a,
                            input logic [17:0] b, input logic [17:0] d,
                            input logic [7:0] op, input logic [35:0] exp_m,
                            input logic [17:0] exp_b);
    apply_stimulus(a, b, d, op, 1'b1);
    #1;
    check_output({tag, " byp m_out"}, byp_m_out, exp_m);
    check_output({tag, " byp valid"}, 36'(byp_out_valid), 36'd1);
    check_output({tag, " byp bcout"}, 36'(byp_bcout), 36'(exp_b));
    tick();
    apply_stimulus(18'd0, 18'd0, 18'd0, 8'h00, 1'b0);
    check_output({tag, " def valid e1"}, 36'(def_out_valid), 36'd0);
    check_output({tag, " mix bcout e1"}, 36'(mix_bcout), 36'(exp_b));
    check_output({tag, " mix valid e1"}, 36'(mix_out_valid), 36'd0);
    tick();
    check_output({tag, " def bcout e2"}, 36'(def_bcout), 36'(exp_b));
    check_output({tag, " def valid e2"}, 36'(def_out_valid), 36'd0);
    check_output({tag, " mix m_out e2"}, mix_m_out, exp_m);
    check_output({tag, " mix valid e2"}, 36'(mix_out_valid), 36'd1);
    tick();
    check_output({tag, " def m_out e3"}, def_m_out, exp_m);
    check_output({tag, " def valid e3"}, 36'(def_out_valid), 36'd1);
    check_output({tag, " mix valid e3"}, 36'(mix_out_valid), 36'd0);
  endtask

  initial begin
    rst_aSYNC = 1'b1;
    ce0 = 1'b1;
    ce1 = 1'b1;
    cem = 1'b1;
    apply_stimulus(18'd3, 18'd5, 18'd10, 8'h10, 1'b1);

    // Reset state, and reset winning over enabled stages on a live edge.
    #1;
    check_output("reset m_out", def_m_out, 36'd0);
    check_output("reset bcout", 36'(def_bcout), 36'd0);
    check_output("reset valid", 36'(def_out_valid), 36'd0);
    tick();
    check_output("reset edge m_out", def_m_out, 36'd0);
    check_output("reset edge bcout", 36'(def_bcout), 36'd0);
    check_output("reset edge valid", 36'(def_out_valid), 36'd0);
    check_output("reset edge mix valid", 36'(mix_out_valid), 36'd0);
    apply_stimulus(18'd0, 18'd0, 18'd0, 8'h00, 1'b0);
    #3;
    rst_aSYNC = 1'b0;
    $display("[TB] reset released");

    // Directed arithmetic vectors.
    run_vector("add",     18'd3,        18'd5,       18'd10,      8'h10,
               36'd45,           18'd15);
    run_vector("sub",     -18'sd4,      18'd5,       18'd10,      8'h50,
               36'hF_FFFF_FFEC,  18'd5);
    run_vector("nopre",   -18'sd4,      18'd5,       18'd10,      8'h40,
               36'hF_FFFF_FFEC,  18'd5);
    run_vector("subneg",  -18'sd5,      18'd7,       18'd3,       8'h50,
               36'd20,           18'h3FFFC);
    run_vector("wrap",    18'd1,        18'd1,       18'h1FFFF,   8'h10,
               36'hF_FFFE_0000,  18'h20000);
    run_vector("extreme", 18'h20000,    18'h20000,   18'd0,       8'h00,
               36'h4_0000_0000,  18'h20000);

    // Stream of four samples with a two-cycle stall after the third.
    $display("[TB] stall stream");
    for (int k = 1; k <= 9; k++) begin
      if (k <= 4)
        apply_stimulus(18'(k), 18'd10, 18'd0, 8'h00, 1'b1);
      else if (k >= 7)
        apply_stimulus(18'd0, 18'd0, 18'd0, 8'h00, 1'b0);
      ce0 = !(k == 4 || k == 5);
      ce1 = !(k == 4 || k == 5);
      cem = !(k == 4 || k == 5);
      tick();
      check_output($sformatf("stall valid e%0d", k), 36'(def_out_valid), 36'(stall_v[k-1]));
      check_output($sformatf("stall m_out e%0d", k), def_m_out, stall_m[k-1]);
    end
    ce0 = 1'b1;
    ce1 = 1'b1;
    cem = 1'b1;

    // Reset between edges with three samples in flight.
    $display("[TB] mid-operation reset");
    apply_stimulus(18'd2, 18'd7, 18'd0, 8'h00, 1'b1);
    tick();
    apply_stimulus(18'd3, 18'd7, 18'd0, 8'h00, 1'b1);
    tick();
    apply_stimulus(18'd4, 18'd7, 18'd0, 8'h00, 1'b1);
    tick();
    check_output("inflight m_out", def_m_out, 36'd14);
    check_output("inflight valid", 36'(def_out_valid), 36'd1);
    apply_stimulus(18'd0, 18'd0, 18'd0, 8'h00, 1'b0);
    #2;
    rst_aSYNC = 1'b1;
    #1;
    check_output("midrst m_out", def_m_out, 36'd0);
    check_output("midrst bcout", 36'(def_bcout), 36'd0);
    check_output("midrst valid", 36'(def_out_valid), 36'd0);
    check_output("midrst mix m_out", mix_m_out, 36'd0);
    #2;
    rst_aSYNC = 1'b0;
    run_vector("postrst", 18'd6, 18'd7, 18'd0, 8'h00, 36'd42, 18'd7);
    tick();
    check_output("postrst def valid e4", 36'(def_out_valid), 36'd0);

    $display("== %0d vectors applied, %0d miscompares ==", num_checks, miscompares);
    $finish;
  end

endmodule
